// File: rtl/vga_pixel_unpack_pkg.sv
// Shared VGA definitions: colour-mode encodings, RGB565 colour constants and
// the test-pattern bar palette.
package vga_pixel_unpack_pkg;

  typedef enum logic [1:0] {
    VGA_RGB332_MODE = 2'b00,
    VGA_RGB444_MODE = 2'b01,
    VGA_RGB555_MODE = 2'b10,
    VGA_RGB565_MODE = 2'b11
  } vga_mode_e;

  localparam int VGA_TEST_BAR_NUM = 8;

  localparam logic [15:0] VGA_RGB565_COLOR_WHITE  = 16'hFFFF;
  localparam logic [15:0] VGA_RGB565_COLOR_YELLOW = 16'hFFE0;
  localparam logic [15:0] VGA_RGB565_COLOR_CYAN   = 16'h07FF;
  localparam logic [15:0] VGA_RGB565_COLOR_GREEN  = 16'h07E0;
  localparam logic [15:0] VGA_RGB565_COLOR_PURPLE = 16'hF81F;
  localparam logic [15:0] VGA_RGB565_COLOR_RED    = 16'hF800;
  localparam logic [15:0] VGA_RGB565_COLOR_BLUE   = 16'h001F;
  localparam logic [15:0] VGA_RGB565_COLOR_BLACK  = 16'h0000;

  function automatic logic [15:0] vga_bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return VGA_RGB565_COLOR_WHITE;
      3'd1:    return VGA_RGB565_COLOR_YELLOW;
      3'd2:    return VGA_RGB565_COLOR_CYAN;
      3'd3:    return VGA_RGB565_COLOR_GREEN;
      3'd4:    return VGA_RGB565_COLOR_PURPLE;
      3'd5:    return VGA_RGB565_COLOR_RED;
      3'd6:    return VGA_RGB565_COLOR_BLUE;
      default: return VGA_RGB565_COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pixel_unpack_expand.sv
// Combinational expansion of one pixel slot to RGB565 by MSB replication.
module vga_color_expand
  import vga_pixel_unpack_pkg::*;
(
  input  vga_mode_e   mode_i,
  input  logic [15:0] slot_i,
  output logic [4:0]  r_o,
  output logic [5:0]  g_o,
  output logic [4:0]  b_o
);

  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    case (mode_i)
      VGA_RGB332_MODE: begin
        r_o = {slot_i[7:5], slot_i[7:6]};
        g_o = {slot_i[4:2], slot_i[4:2]};
        b_o = {slot_i[1:0], slot_i[1:0], slot_i[1]};
      end
      VGA_RGB444_MODE: begin
        r_o = {slot_i[11:8], slot_i[11]};
        g_o = {slot_i[7:4], slot_i[7:6]};
        b_o = {slot_i[3:0], slot_i[3]};
      end
      VGA_RGB555_MODE: begin
        r_o = slot_i[14:10];
        g_o = {slot_i[9:5], slot_i[9]};
        b_o = slot_i[4:0];
      end
      default: begin
        r_o = slot_i[15:11];
        g_o = slot_i[10:5];
        b_o = slot_i[4:0];
      end
    endcase
  end

endmodule

// File: rtl/vga_pixel_unpack.sv
// Pixel stage: unpacks framebuffer FIFO words into RGB565 pixels on request,
// or generates colour bars in test mode. Flags FIFO underrun.
module vga_pixel_unpack
  import vga_pixel_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BAR_W      = 80
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic                  test_i,
  input  logic                  frame_start_i,
  input  logic                  line_start_i,
  input  logic                  pix_req_i,
  input  logic                  fifo_valid_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_ready_o,
  output logic                  pix_valid_o,
  output logic [4:0]            pix_r_o,
  output logic [5:0]            pix_g_o,
  output logic [4:0]            pix_b_o,
  output logic                  underrun_o
);

  localparam int              PosW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PosW-1:0] BAR_LAST = PosW'(BAR_W - 1);
  localparam logic [2:0]      BAR_MAX  = 3'(VGA_TEST_BAR_NUM - 1);

  vga_mode_e             mode_q, mode_d;
  logic                  test_q, test_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_vld_q, buf_vld_d;
  logic [1:0]            slot_q, slot_d;
  logic [PosW-1:0]       pos_q, pos_d;
  logic [2:0]            bar_q, bar_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  underrun_q, underrun_d;
  logic [4:0]            r_q, r_d, b_q, b_d;
  logic [5:0]            g_q, g_d;

  logic [1:0]      slot_last;
  logic            at_last, pop;
  logic [15:0]     slot_pix, bar_pix;
  logic [4:0]      exp_r, exp_b;
  logic [5:0]      exp_g;
  logic [PosW-1:0] pos_cur;
  logic [2:0]      bar_cur;

  assign slot_last    = (mode_q == VGA_RGB332_MODE) ? 2'd3 : 2'd1;
  assign at_last      = (slot_q == slot_last);
  assign fifo_ready_o = rst_n_i & en_i & ~test_q & ~frame_start_i &
                        (~buf_vld_q | (pix_req_i & at_last));
  assign pop          = fifo_valid_i & fifo_ready_o;

  always_comb begin
    slot_pix = '0;
    if (mode_q == VGA_RGB332_MODE) slot_pix[7:0] = buf_q[{slot_q, 3'b000} +: 8];
    else                           slot_pix      = buf_q[{slot_q[0], 4'b0000} +: 16];
  end

  vga_color_expand u_expand (
    .mode_i (mode_q),
    .slot_i (slot_pix),
    .r_o    (exp_r),
    .g_o    (exp_g),
    .b_o    (exp_b)
  );

  // Bar position is a down-counter within the bar; a line start in the same
  // cycle as a request makes that request the first pixel of the line.
  assign pos_cur = line_start_i ? BAR_LAST : pos_q;
  assign bar_cur = line_start_i ? 3'd0 : bar_q;
  assign bar_pix = vga_bar_color(bar_cur);

  always_comb begin
    mode_d      = mode_q;
    test_d      = test_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    slot_d      = slot_q;
    pos_d       = pos_cur;
    bar_d       = bar_cur;
    pix_valid_d = pix_req_i;
    underrun_d  = 1'b0;
    r_d         = '0;
    g_d         = '0;
    b_d         = '0;
    if (frame_start_i) begin
      mode_d    = vga_mode_e'(mode_i);
      test_d    = test_i;
      buf_vld_d = 1'b0;
      slot_d    = '0;
    end else if (test_q) begin
      if (pix_req_i) begin
        {r_d, g_d, b_d} = bar_pix;
        if (pos_cur == '0) begin
          pos_d = BAR_LAST;
          if (bar_cur != BAR_MAX) bar_d = bar_cur + 3'd1;
        end else begin
          pos_d = pos_cur - 1'b1;
        end
      end
    end else begin
      if (pix_req_i) begin
        if (buf_vld_q) begin
          {r_d, g_d, b_d} = {exp_r, exp_g, exp_b};
          slot_d = slot_q + 2'd1;
          if (at_last) begin
            buf_vld_d = 1'b0;
            slot_d    = '0;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      // A pop on the last slot overrides the drain above, so there is no bubble.
      if (pop) begin
        buf_d     = fifo_data_i;
        buf_vld_d = 1'b1;
        slot_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      mode_q      <= VGA_RGB565_MODE;
      test_q      <= 1'b0;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      slot_q      <= '0;
      pos_q       <= BAR_LAST;
      bar_q       <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      mode_q      <= mode_d;
      test_q      <= test_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      slot_q      <= slot_d;
      pos_q       <= pos_d;
      bar_q       <= bar_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign underrun_o  = underrun_q;
  assign pix_r_o     = r_q;
  assign pix_g_o     = g_q;
  assign pix_b_o     = b_q;

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Self-checking bench for vga_pixel_unpack: directed scenarios plus random
// traffic, all compared against a pixel-queue reference model.
module tb_vga_pixel_unpack;

  localparam int BAR_W = 80;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        en_i = 1'b0;
  logic [1:0]  mode_i = 2'd3;
  logic        test_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        line_start_i = 1'b0;
  logic        pix_req_i = 1'b0;
  logic        fifo_valid_i = 1'b0;
  logic [31:0] fifo_data_i = '0;
  logic        fifo_ready_o, pix_valid_o, underrun_o;
  logic [4:0]  pix_r_o, pix_b_o;
  logic [5:0]  pix_g_o;

  always #5 clk_i = ~clk_i;

  vga_pixel_unpack #(.DATA_WIDTH(32), .BAR_W(BAR_W)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .en_i          (en_i),
    .mode_i        (mode_i),
    .test_i        (test_i),
    .frame_start_i (frame_start_i),
    .line_start_i  (line_start_i),
    .pix_req_i     (pix_req_i),
    .fifo_valid_i  (fifo_valid_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_ready_o  (fifo_ready_o),
    .pix_valid_o   (pix_valid_o),
    .pix_r_o       (pix_r_o),
    .pix_g_o       (pix_g_o),
    .pix_b_o       (pix_b_o),
    .underrun_o    (underrun_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of already-expanded pixels still held in the word buffer.
  logic [15:0] m_q[$];
  int          m_mode = 3;
  bit          m_test = 1'b0;
  int          m_cnt = 0;
  logic        exp_vld = 1'b0;
  logic        exp_und = 1'b0;
  logic [15:0] exp_pix = '0;
  logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int mode, input logic [31:0] w, input int i);
    int p, r, g, b, rr, gg, bb;
    if (mode == 0) p = int'((w >> (8 * i)) & 32'hFF);
    else           p = int'((w >> (16 * i)) & 32'hFFFF);
    case (mode)
      0: begin
        r = p / 32; g = (p / 4) % 8; b = p % 4;
        rr = r * 4 + r / 2; gg = g * 8 + g; bb = b * 8 + b * 2 + b / 2;
      end
      1: begin
        r = (p / 256) % 16; g = (p / 16) % 16; b = p % 16;
        rr = r * 2 + r / 8; gg = g * 4 + g / 4; bb = b * 2 + b / 8;
      end
      2: begin
        r = (p / 1024) % 32; g = (p / 32) % 32; b = p % 32;
        rr = r; gg = g * 2 + g / 16; bb = b;
      end
      default: begin
        rr = p / 2048; gg = (p / 32) % 64; bb = p % 32;
      end
    endcase
    return 16'(rr * 2048 + gg * 32 + bb);
  endfunction

  task automatic cyc(input bit rst, input bit en, input logic [1:0] mode, input bit test,
                     input bit fs, input bit ls, input bit req, input bit fv,
                     input logic [31:0] fd);
    bit exp_rdy;
    int bar;
    rst_n_i = rst; en_i = en; mode_i = mode; test_i = test;
    frame_start_i = fs; line_start_i = ls; pix_req_i = req;
    fifo_valid_i = fv; fifo_data_i = fd;
    @(negedge clk_i);
    exp_rdy = rst && en && !m_test && !fs && (m_q.size() == 0 || (req && m_q.size() == 1));
    chk("fifo_ready", fifo_ready_o, exp_rdy);
    if (!rst || !en) begin
      m_q.delete();
      m_mode = 3; m_test = 1'b0; m_cnt = 0;
      exp_vld = 1'b0; exp_und = 1'b0; exp_pix = '0;
    end else begin
      exp_vld = req; exp_und = 1'b0; exp_pix = '0;
      if (ls) m_cnt = 0;
      if (fs) begin
        m_mode = int'(mode); m_test = test; m_q.delete();
      end else if (m_test) begin
        if (req) begin
          bar = m_cnt / BAR_W;
          if (bar > 7) bar = 7;
          exp_pix = bars[bar];
          m_cnt++;
        end
      end else begin
        if (req) begin
          if (m_q.size() > 0) exp_pix = m_q.pop_front();
          else                exp_und = 1'b1;
        end
        if (exp_rdy && fv)
          for (int i = 0; i < ((m_mode == 0) ? 4 : 2); i++) m_q.push_back(ref_pix(m_mode, fd, i));
      end
    end
    @(posedge clk_i);
    #1;
    chk("pix_valid", pix_valid_o, exp_vld);
    chk("underrun", underrun_o, exp_und);
    chk("pixel", {pix_r_o, pix_g_o, pix_b_o}, exp_pix);
  endtask

  initial begin
    // reset held with a word on offer
    repeat (3) cyc(0, 1, 3, 0, 0, 0, 0, 1, 32'hDEADBEEF);

    // RGB565: one word, two pixels
    cyc(1, 1, 3, 0, 1, 0, 0, 0, '0);
    cyc(1, 1, 3, 0, 0, 0, 0, 1, 32'h07E0_F800);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, '0);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, '0);

    // RGB332 back-to-back words
    cyc(1, 1, 0, 0, 1, 0, 0, 0, '0);
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'h031C_E0FF);
    for (int k = 0; k < 12; k++)
      cyc(1, 1, 0, 0, 0, 0, 1, 1, (k < 4) ? 32'h1234_5678 : 32'h9ABC_DEF0);

    // underrun then recovery
    cyc(1, 1, 3, 0, 1, 0, 0, 0, '0);
    repeat (3) cyc(1, 1, 3, 0, 0, 0, 1, 0, '0);
    cyc(1, 1, 3, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, '0);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, '0);

    // flush mid-word, mode change only at frame start
    cyc(1, 1, 3, 0, 1, 0, 0, 0, '0);
    cyc(1, 1, 3, 0, 0, 0, 0, 1, 32'hAAAA_5555);
    cyc(1, 1, 3, 0, 0, 0, 1, 0, '0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, '0);
    cyc(1, 1, 1, 0, 1, 0, 1, 1, 32'h1111_2222);
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 32'h0F0F_1234);
    cyc(1, 1, 1, 0, 0, 0, 1, 0, '0);
    cyc(1, 1, 1, 0, 0, 0, 1, 0, '0);

    // test pattern: one line of 640 plus saturation past the last bar
    cyc(1, 1, 3, 1, 1, 0, 0, 1, $urandom);
    cyc(1, 1, 3, 1, 0, 1, 0, 1, $urandom);
    for (int k = 0; k < 740; k++) cyc(1, 1, 3, 1, 0, 0, 1, 1, $urandom);
    cyc(1, 1, 3, 1, 0, 1, 1, 1, $urandom);
    repeat (5) cyc(1, 1, 3, 1, 0, 0, 1, 0, '0);

    // randomized traffic including enable drops and resets
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) != 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
